sdr_ctrl_cmd: RTL

SDR_CTRL_CMD -- requirements
Module: sdr_ctrl_cmd

---
 rtl/sdr_ctrl_cmd.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/sdr_ctrl_cmd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sdr_ctrl_cmd                                                     |
// | Brief   : SDRAM command sequencer for single-word APB reads/writes with    |
// |           auto-precharge; optional periodic auto-refresh under the         |
// |           SDR_AUTO_REFRESH_EN macro.                                       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sdr_ctrl_cmd #(
    parameter int NUM_CLK_tRCD  = 2,
    parameter int NUM_CLK_CL    = 2,
    parameter int NUM_CLK_READ  = 2,
    parameter int NUM_CLK_WRITE = 2,
    parameter int NUM_CLK_tDAL  = 4,
    parameter int NUM_CLK_tRFC  = 7,
    parameter int NUM_CLK_REF   = 1560
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        init_done,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [22:0] paddr,
    output logic        pready,
    output logic [3:0]  cState,
    output logic [3:0]  clkCNT,
    output logic        sdr_CSn,
    output logic        sdr_RASn,
    output logic        sdr_CASn,
    output logic        sdr_WEn,
    output logic [1:0]  sdr_BA,
    output logic [11:0] sdr_A
);

    localparam logic [3:0] c_idle   = 4'd0;
    localparam logic [3:0] c_ACTIVE = 4'd1;
    localparam logic [3:0] c_tRCD   = 4'd2;
    localparam logic [3:0] c_READA  = 4'd3;
    localparam logic [3:0] c_cl     = 4'd4;
    localparam logic [3:0] c_rdata  = 4'd5;
    localparam logic [3:0] c_WRITEA = 4'd6;
    localparam logic [3:0] c_wdata  = 4'd7;
    localparam logic [3:0] c_tDAL   = 4'd8;
    localparam logic [3:0] c_AR     = 4'd9;
    localparam logic [3:0] c_tRFC   = 4'd10;

    localparam logic [3:0] c_CMD_NOP  = 4'b0111;
    localparam logic [3:0] c_CMD_ACT  = 4'b0011;
    localparam logic [3:0] c_CMD_RDA  = 4'b0101;
    localparam logic [3:0] c_CMD_WRA  = 4'b0100;
    localparam logic [3:0] c_CMD_AREF = 4'b0001;

    function automatic logic [3:0] f_load(input int n);
        return 4'(n - 1);
    endfunction

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [3:0] r_cnt;
    logic [3:0] w_next_cnt;
    logic       r_wr;
    logic [1:0] r_ba;
    logic [8:0] r_col;
    logic       w_ref_req;
    logic       w_start;
    logic       w_cnt_done;
    logic [3:0] w_cmd;

    assign w_start    = psel & penable & init_done;
    assign w_cnt_done = (r_cnt == 4'd0);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (init_done && w_ref_req) w_next_state = c_AR;
                else if (w_start)           w_next_state = c_ACTIVE;
            end
            c_ACTIVE: w_next_state = c_tRCD;
            c_tRCD:   if (w_cnt_done) w_next_state = r_wr ? c_WRITEA : c_READA;
            c_READA:  w_next_state = c_cl;
            c_cl:     if (w_cnt_done) w_next_state = c_rdata;
            c_rdata:  if (w_cnt_done) w_next_state = c_idle;
            c_WRITEA: w_next_state = c_wdata;
            c_wdata:  if (w_cnt_done) w_next_state = c_tDAL;
            c_tDAL:   if (w_cnt_done) w_next_state = c_idle;
            c_AR:     w_next_state = c_tRFC;
            // A request that lost arbitration to refresh goes straight to ACTIVE.
            c_tRFC:   if (w_cnt_done) w_next_state = (w_start && !w_ref_req) ? c_ACTIVE : c_idle;
            default:  w_next_state = c_idle;
        endcase
    end

    always_comb begin
        w_next_cnt = 4'd0;
        if (w_next_state != r_state) begin
            case (w_next_state)
                c_tRCD:  w_next_cnt = f_load(NUM_CLK_tRCD);
                c_cl:    w_next_cnt = f_load(NUM_CLK_CL);
                c_rdata: w_next_cnt = f_load(NUM_CLK_READ);
                c_wdata: w_next_cnt = f_load(NUM_CLK_WRITE);
                c_tDAL:  w_next_cnt = f_load(NUM_CLK_tDAL);
                c_tRFC:  w_next_cnt = f_load(NUM_CLK_tRFC);
                default: w_next_cnt = 4'd0;
            endcase
        end else if (!w_cnt_done) begin
            w_next_cnt = r_cnt - 4'd1;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= c_idle;
            r_cnt   <= 4'd0;
            r_wr    <= 1'b0;
            r_ba    <= 2'd0;
            r_col   <= 9'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (r_state == c_ACTIVE) begin
                r_wr  <= pwrite;
                r_ba  <= paddr[22:21];
                r_col <= paddr[8:0];
            end
        end
    end

`ifdef SDR_AUTO_REFRESH_EN
    localparam int REF_W = (NUM_CLK_REF > 1) ? $clog2(NUM_CLK_REF) : 1;

    logic [REF_W-1:0] r_ref_cnt;
    logic             r_ref_req;

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_ref_cnt <= '0;
            r_ref_req <= 1'b0;
        end else begin
            if (r_ref_cnt == REF_W'(NUM_CLK_REF - 1)) begin
                r_ref_cnt <= '0;
                r_ref_req <= 1'b1;
            end else begin
                r_ref_cnt <= r_ref_cnt + 1'b1;
            end
            // Clearing takes priority so a coincident wrap cannot queue a second refresh.
            if (r_state == c_idle && w_next_state == c_AR)
                r_ref_req <= 1'b0;
        end
    end

    assign w_ref_req = r_ref_req;
`else
    logic w_unused_ref;
    assign w_unused_ref = (NUM_CLK_REF > 0);
    assign w_ref_req    = 1'b0;
`endif

    always_comb begin
        w_cmd  = c_CMD_NOP;
        sdr_BA = 2'd0;
        sdr_A  = 12'd0;
        case (r_state)
            c_ACTIVE: begin
                w_cmd  = c_CMD_ACT;
                sdr_BA = paddr[22:21];
                sdr_A  = paddr[20:9];
            end
            c_READA: begin
                w_cmd  = c_CMD_RDA;
                sdr_BA = r_ba;
                sdr_A  = {3'b010, r_col};
            end
            c_WRITEA: begin
                w_cmd  = c_CMD_WRA;
                sdr_BA = r_ba;
                sdr_A  = {3'b010, r_col};
            end
            c_AR:    w_cmd = c_CMD_AREF;
            default: w_cmd = c_CMD_NOP;
        endcase
    end

    assign {sdr_CSn, sdr_RASn, sdr_CASn, sdr_WEn} = w_cmd;

    assign pready = ((r_state == c_rdata) || (r_state == c_tDAL)) && w_cnt_done;
    assign cState = r_state;
    assign clkCNT = r_cnt;

endmodule
`default_nettype wire
